game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): SCREEN_W 640 visible width; FLOOR_Y 440 bird death row; BIRD_Y0 240 start row; PIPE_SPEED 2 px/frame; GRAVITY 1 px/frame^2; FLAP_V -8 flap velocity; VMAX 8 max fall velocity; OVER_FRAMES 60 min frames in OVER.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 pixel clock; rst_n in 1 synchronous active-low reset.
REQ-003 frame_tick in 1: one-cycle pulse, once per frame, issued at vertical blank.
REQ-004 flap in 1: button level, already synchronised to clk.
REQ-005 bird_color in 1 and pipe_color in 1: per-pixel renderer hit flags.
REQ-006 state out 2: 00 IDLE, 01 PLAY, 10 OVER.
REQ-007 bird_y out 10: bird top row.
REQ-008 pipe_x out 10: pipe left column.
REQ-009 gap_y out 10: pipe gap top row.
REQ-010 score out 8: pipes passed.
REQ-011 game_over out 1: high iff state==OVER.

Function
REQ-012 SHALL detect a flap rising edge as flap=1 with flap registered 0 on the previous cycle.
REQ-013 SHALL set flap_pending on any flap edge and clear it on frame_tick; an edge coincident with frame_tick counts for that tick.
REQ-014 SHALL set sticky hit when bird_color & pipe_color are both 1 in the same cycle while in PLAY; hit clears on entry to PLAY.
REQ-015 IDLE: bird_y=BIRD_Y0, vel=0, pipe_x=SCREEN_W, score held; flap edge -> PLAY on the next cycle, clearing score, hit and flap_pending.
REQ-016 PLAY, on frame_tick: vel_next = flap_pending ? FLAP_V : min(vel+GRAVITY, VMAX); bird_y_next = bird_y + vel_next, signed 11-bit arithmetic.
REQ-017 If bird_y_next < 0, bird_y SHALL be 0 and vel 0 (ceiling clamp, not fatal).
REQ-018 PLAY, on frame_tick: if pipe_x < PIPE_SPEED, pipe_x SHALL load SCREEN_W, gap_y SHALL load 64 + (lfsr[7:0] mod 256), and score SHALL increment, saturating at 255; otherwise pipe_x -= PIPE_SPEED.
REQ-019 PLAY -> OVER on frame_tick when hit==1 or bird_y_next >= FLOOR_Y; on that tick, positions SHALL freeze at their pre-tick values.
REQ-020 OVER: the frame counter SHALL count frame_ticks, saturating at OVER_FRAMES; a flap edge with counter==OVER_FRAMES SHALL go to IDLE; earlier flap edges SHALL be ignored.
REQ-021 LFSR: 8-bit, x^8+x^6+x^5+x^4+1, seed 8'hA5; it SHALL step every clk in all states and never reach 0.
REQ-022 Outputs SHALL be registered, with no combinational path from any input to any output.
REQ-023 Without frame_tick, no position, velocity or score SHALL change.

Reset
REQ-024 With rst_n=0 at a clk edge, state SHALL be IDLE, bird_y BIRD_Y0, vel 0, pipe_x SCREEN_W, gap_y 160, score 0, hit 0, flap_pending 0, frame counter 0, LFSR 8'hA5, game_over 0.
REQ-025 Reset SHALL override every other input in any state, including mid-PLAY and mid-OVER.

Verification
REQ-026 Reset, then a flap pulse: state 00 -> 01 one cycle after the edge; score 0; pipe_x 640.
REQ-027 PLAY with no flap for 3 ticks from rest: vel 1,2,3; bird_y 241,243,246.
REQ-028 PLAY with flap asserted on the same cycle as frame_tick: vel -8; bird_y 240 -> 232; flap_pending 0 afterwards.
REQ-029 pipe_x=1 at a tick in PLAY: pipe_x 640; score increments; score 255 stays 255.
REQ-030 Single cycle with bird_color=pipe_color=1, then the next tick: state 10, game_over 1, bird_y unchanged; a flap before 60 ticks is ignored; a flap after 60 ticks returns state to 00.
REQ-031 rst_n=0 mid-PLAY with score 5: all outputs return to the REQ-024 values one cycle later.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: flappy-bird style game state machine (bird physics, scrolling pipe, score, collision).
// Latency: every output is a register; input effects appear one clk after the sampling edge.
// Flow: no handshake; positions advance only on frame_tick, flap edges are latched until the next tick.
// Ports: clk/rst_n (sync active-low), frame_tick (vblank pulse), flap (synchronised button),
//        bird_color/pipe_color (renderer hit flags) -> state, bird_y, pipe_x, gap_y, score, game_over.
module game_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int FLOOR_Y     = 440,
  parameter int BIRD_Y0     = 240,
  parameter int PIPE_SPEED  = 2,
  parameter int GRAVITY     = 1,
  parameter int FLAP_V      = -8,
  parameter int VMAX        = 8,
  parameter int OVER_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       flap,
  input  logic       bird_color,
  input  logic       pipe_color,
  output logic [1:0] state,
  output logic [9:0] bird_y,
  output logic [9:0] pipe_x,
  output logic [9:0] gap_y,
  output logic [7:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;

  localparam int FCW = $clog2(OVER_FRAMES + 1);

  localparam logic signed [10:0] FLAP_V11  = 11'(FLAP_V);
  localparam logic signed [10:0] GRAVITY11 = 11'(GRAVITY);
  localparam logic signed [10:0] VMAX11    = 11'(VMAX);
  localparam logic signed [10:0] FLOOR11   = 11'(FLOOR_Y);
  localparam logic [9:0]         BIRD_Y0_10  = 10'(BIRD_Y0);
  localparam logic [9:0]         SCREEN_W10  = 10'(SCREEN_W);
  localparam logic [9:0]         PIPE_SPD10  = 10'(PIPE_SPEED);
  localparam logic [FCW-1:0]     OVER_CNT    = FCW'(OVER_FRAMES);

  state_t             state_q, state_d;
  logic               flap_q;
  logic               flap_pending;
  logic               hit;
  logic signed [7:0]  vel;
  logic [FCW-1:0]     fcnt;
  logic [7:0]         lfsr;

  logic               flap_edge;
  logic               pend_eff;
  logic signed [10:0] vel_ext;
  logic signed [10:0] vel_grav;
  logic signed [10:0] vel_next;
  logic signed [10:0] y_next;
  logic               die;
  logic               wrap;
  logic               lfsr_fb;

  // FSM strobes
  logic               start;
  logic               to_over;
  logic               to_idle;
  logic               move;

  assign flap_edge = flap & ~flap_q;
  // A flap edge landing on the tick cycle itself must still count for that tick.
  assign pend_eff  = flap_pending | flap_edge;
  assign vel_ext   = $signed({{3{vel[7]}}, vel});
  assign vel_grav  = vel_ext + GRAVITY11;
  assign vel_next  = pend_eff ? FLAP_V11 : ((vel_grav > VMAX11) ? VMAX11 : vel_grav);
  assign y_next    = $signed({1'b0, bird_y}) + vel_next;
  assign die       = hit | (y_next >= FLOOR11);
  assign wrap      = (pipe_x < PIPE_SPD10);
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    to_over = 1'b0;
    to_idle = 1'b0;
    move    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flap_edge) begin
          state_d = S_PLAY;
          start   = 1'b1;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (die) begin
            state_d = S_OVER;
            to_over = 1'b1;
          end else begin
            move = 1'b1;
          end
        end
      end
      S_OVER: begin
        if (flap_edge && (fcnt == OVER_CNT)) begin
          state_d = S_IDLE;
          to_idle = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flap_q       <= 1'b0;
      flap_pending <= 1'b0;
      hit          <= 1'b0;
      vel          <= 8'sd0;
      fcnt         <= '0;
      lfsr         <= 8'hA5;
      bird_y       <= BIRD_Y0_10;
      pipe_x       <= SCREEN_W10;
      gap_y        <= 10'd160;
      score        <= 8'd0;
      game_over    <= 1'b0;
    end else begin
      // Maximal-length taps from a nonzero seed: the register can never lock at zero.
      lfsr      <= {lfsr[6:0], lfsr_fb};
      flap_q    <= flap;
      game_over <= (state_d == S_OVER);

      if (start || frame_tick) flap_pending <= 1'b0;
      else if (flap_edge)      flap_pending <= 1'b1;

      if (start)
        hit <= 1'b0;
      else if ((state_q == S_PLAY) && bird_color && pipe_color)
        hit <= 1'b1;

      if (start) score <= 8'd0;

      if (to_idle) begin
        bird_y <= BIRD_Y0_10;
        vel    <= 8'sd0;
        pipe_x <= SCREEN_W10;
      end

      // On the dying tick nothing moves: positions stay at their pre-tick values.
      if (move) begin
        if (y_next[10]) begin
          bird_y <= 10'd0;
          vel    <= 8'sd0;
        end else begin
          bird_y <= y_next[9:0];
          vel    <= vel_next[7:0];
        end
        if (wrap) begin
          pipe_x <= SCREEN_W10;
          gap_y  <= 10'd64 + {2'b00, lfsr};
          if (score != 8'hFF) score <= score + 8'd1;
        end else begin
          pipe_x <= pipe_x - PIPE_SPD10;
        end
      end

      // The tick that ends the game does not count towards the OVER hold-off.
      if (to_over)
        fcnt <= '0;
      else if ((state_q == S_OVER) && frame_tick && (fcnt != OVER_CNT))
        fcnt <= fcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: scoreboard bench for game_ctrl; a second instance with a 9-pixel screen
// exercises pipe wrap at pipe_x=1 and score saturation in a short run.
// Inputs driven 1ns after posedge, outputs sampled at the same point.
module tb_game_ctrl;

  typedef struct packed {
    logic [1:0] st;
    logic [9:0] y;
    logic [9:0] px;
    logic [9:0] gy;
    logic [7:0] sc;
    logic       go;
  } snap_t;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       flap;
  logic       bird_color;
  logic       pipe_color;

  logic [1:0] state,   s_state;
  logic [9:0] bird_y,  s_bird_y;
  logic [9:0] pipe_x,  s_pipe_x;
  logic [9:0] gap_y,   s_gap_y;
  logic [7:0] score,   s_score;
  logic       game_over, s_game_over;

  snap_t obs, obs_s, want;
  snap_t sb[$];
  int    sbi[$];
  int    total = 0;
  int    bad   = 0;
  logic [7:0] m_lfsr;

  game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .flap(flap),
    .bird_color(bird_color), .pipe_color(pipe_color),
    .state(state), .bird_y(bird_y), .pipe_x(pipe_x), .gap_y(gap_y),
    .score(score), .game_over(game_over)
  );

  game_ctrl #(.SCREEN_W(9)) dut_s (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .flap(flap),
    .bird_color(bird_color), .pipe_color(pipe_color),
    .state(s_state), .bird_y(s_bird_y), .pipe_x(s_pipe_x), .gap_y(s_gap_y),
    .score(s_score), .game_over(s_game_over)
  );

  assign obs   = {state, bird_y, pipe_x, gap_y, score, game_over};
  assign obs_s = {s_state, s_bird_y, s_pipe_x, s_gap_y, s_score, s_game_over};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference sequence for x^8+x^6+x^5+x^4+1, seed A5, one step per clk.
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic snap_t mk(int st, int y, int px, int gy, int sc, int go);
    snap_t s;
    s.st = 2'(st); s.y = 10'(y); s.px = 10'(px); s.gy = 10'(gy); s.sc = 8'(sc); s.go = 1'(go);
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d y=%0d px=%0d gy=%0d sc=%0d go=%0d", s.st, s.y, s.px, s.gy, s.sc, s.go);
  endfunction

  task automatic drive(input logic f, input logic t, input logic c);
    flap = f; frame_tick = t; bird_color = c; pipe_color = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic start_play();
    drive(1, 0, 0);
    drive(0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 1);
    sb.push_back(mk(0, 240, 640, 160, 0, 0));
    drive(1, 1, 1);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL reset_main: got %s want %s", fmt(obs), fmt(want)); end
    want = mk(0, 240, 9, 160, 0, 0); total++;
    if (obs_s !== want) begin bad++; $display("FAIL reset_small: got %s want %s", fmt(obs_s), fmt(want)); end
    drive(0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0);
  endtask

  task automatic test_start();
    sb.push_back(mk(1, 240, 640, 160, 0, 0));
    drive(1, 0, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL start: got %s want %s", fmt(obs), fmt(want)); end
    sb.push_back(mk(1, 240, 640, 160, 0, 0));
    for (int i = 0; i < 5; i++) drive(0, 0, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL no_tick_hold: got %s want %s", fmt(obs), fmt(want)); end
  endtask

  task automatic test_gravity();
    int ey[3];
    ey[0] = 241; ey[1] = 243; ey[2] = 246;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(1, ey[i], 640 - 2 * (i + 1), 160, 0, 0));
      drive(0, 1, 0);
      want = sb.pop_front(); total++;
      if (obs !== want) begin bad++; $display("FAIL gravity_%0d: got %s want %s", i, fmt(obs), fmt(want)); end
      drive(0, 0, 0);
    end
  endtask

  task automatic test_flap();
    do_reset();
    start_play();
    sb.push_back(mk(1, 232, 638, 160, 0, 0));
    drive(1, 1, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL flap_on_tick: got %s want %s", fmt(obs), fmt(want)); end
    drive(0, 0, 0);
    sb.push_back(mk(1, 225, 636, 160, 0, 0));
    drive(0, 1, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL pending_cleared: got %s want %s", fmt(obs), fmt(want)); end
    sb.push_back(mk(1, 225, 636, 160, 0, 0));
    drive(1, 0, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL flap_no_move: got %s want %s", fmt(obs), fmt(want)); end
    for (int i = 0; i < 3; i++) drive(0, 0, 0);
    sb.push_back(mk(1, 217, 634, 160, 0, 0));
    drive(0, 1, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL pending_used: got %s want %s", fmt(obs), fmt(want)); end
    drive(0, 0, 0);
    sb.push_back(mk(1, 210, 632, 160, 0, 0));
    drive(0, 1, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL after_flap_grav: got %s want %s", fmt(obs), fmt(want)); end
    drive(0, 0, 0);
    for (int i = 0; i < 27; i++) begin
      drive(1, 1, 0);
      drive(0, 0, 0);
    end
    sb.push_back(mk(1, 0, 578, 160, 0, 0));
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL ceiling_clamp: got %s want %s", fmt(obs), fmt(want)); end
    sb.push_back(mk(1, 1, 576, 160, 0, 0));
    drive(0, 1, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL ceiling_vel0: got %s want %s", fmt(obs), fmt(want)); end
    drive(0, 0, 0);
  endtask

  task automatic test_floor();
    do_reset();
    start_play();
    for (int i = 0; i < 28; i++) begin
      drive(0, 1, 0);
      drive(0, 0, 0);
    end
    sb.push_back(mk(1, 436, 584, 160, 0, 0));
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL pre_floor: got %s want %s", fmt(obs), fmt(want)); end
    sb.push_back(mk(2, 436, 584, 160, 0, 1));
    drive(0, 1, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL floor_over: got %s want %s", fmt(obs), fmt(want)); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0);
      drive(0, 1, 0);
    end
    sb.push_back(mk(2, 436, 584, 160, 0, 1));
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL over_frozen: got %s want %s", fmt(obs), fmt(want)); end
    rst_n = 1'b0;
    sb.push_back(mk(0, 240, 640, 160, 0, 0));
    drive(1, 1, 1);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL reset_mid_over: got %s want %s", fmt(obs), fmt(want)); end
    drive(0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0);
  endtask

  task automatic test_collision();
    do_reset();
    start_play();
    drive(0, 1, 0);
    sb.push_back(mk(1, 241, 638, 160, 0, 0));
    drive(0, 0, 1);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL hit_no_tick: got %s want %s", fmt(obs), fmt(want)); end
    drive(0, 0, 0);
    sb.push_back(mk(2, 241, 638, 160, 0, 1));
    drive(0, 1, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL hit_over: got %s want %s", fmt(obs), fmt(want)); end
    drive(0, 0, 0);
    for (int i = 0; i < 59; i++) begin
      drive(0, 1, 0);
      drive(0, 0, 0);
    end
    sb.push_back(mk(2, 241, 638, 160, 0, 1));
    drive(1, 0, 0);
    drive(0, 0, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL early_flap_ignored: got %s want %s", fmt(obs), fmt(want)); end
    drive(0, 1, 0);
    drive(0, 0, 0);
    sb.push_back(mk(0, 240, 640, 160, 0, 0));
    drive(1, 0, 0);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL over_to_idle: got %s want %s", fmt(obs), fmt(want)); end
    drive(0, 0, 0);
  endtask

  task automatic test_pipe_wrap();
    do_reset();
    start_play();
    for (int w = 1; w <= 257; w++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1, 1, 0);
        drive(0, 0, 0);
      end
      total++;
      if (s_pipe_x !== 10'd1) begin bad++; $display("FAIL pipe_pre_wrap_%0d: got %0d want 1", w, s_pipe_x); end
      sbi.push_back(64 + int'(m_lfsr));
      sbi.push_back((w > 255) ? 255 : w);
      drive(1, 1, 0);
      begin
        int eg, es;
        eg = sbi.pop_front();
        es = sbi.pop_front();
        total++;
        if (s_pipe_x !== 10'd9 || s_state !== 2'd1) begin
          bad++; $display("FAIL pipe_wrap_%0d: got px=%0d st=%0d want px=9 st=1", w, s_pipe_x, s_state);
        end
        total++;
        if (s_gap_y !== 10'(eg)) begin bad++; $display("FAIL gap_%0d: got %0d want %0d", w, s_gap_y, eg); end
        total++;
        if (s_score !== 8'(es)) begin bad++; $display("FAIL score_%0d: got %0d want %0d", w, s_score, es); end
      end
      drive(0, 0, 0);
    end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    start_play();
    for (int i = 0; i < 25; i++) begin
      drive(1, 1, 0);
      drive(0, 0, 0);
    end
    sbi.push_back(5);
    begin
      int es;
      es = sbi.pop_front();
      total++;
      if (s_score !== 8'(es) || s_state !== 2'd1) begin
        bad++; $display("FAIL score5_play: got sc=%0d st=%0d want sc=%0d st=1", s_score, s_state, es);
      end
    end
    rst_n = 1'b0;
    sb.push_back(mk(0, 240, 640, 160, 0, 0));
    sb.push_back(mk(0, 240, 9, 160, 0, 0));
    drive(1, 1, 1);
    want = sb.pop_front(); total++;
    if (obs !== want) begin bad++; $display("FAIL reset_mid_play: got %s want %s", fmt(obs), fmt(want)); end
    want = sb.pop_front(); total++;
    if (obs_s !== want) begin bad++; $display("FAIL reset_mid_play_s: got %s want %s", fmt(obs_s), fmt(want)); end
    drive(0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; flap = 1'b0; frame_tick = 1'b0; bird_color = 1'b0; pipe_color = 1'b0;
    test_reset();
    test_start();
    test_gravity();
    test_flap();
    test_floor();
    test_collision();
    test_pipe_wrap();
    test_reset_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
